// File: rtl/cosim_trace_if.sv
// Checker-side trace stream: one valid/ready record channel tagged with its source hart.
interface cosim_trace_if #(
    parameter int NHARTS = 2,
    parameter int REC_W  = 227
);
    localparam int HID_W = (NHARTS > 1) ? $clog2(NHARTS) : 1;

    logic             out_valid;
    logic             out_ready;
    logic [HID_W-1:0] out_hartid;
    logic [REC_W-1:0] out_rec;
    logic [63:0]      out_cycle;

    modport master (
        output out_valid,
        output out_hartid,
        output out_rec,
        output out_cycle,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_hartid,
        input  out_rec,
        input  out_cycle,
        output out_ready
    );
endinterface

// File: rtl/cosim_trace_arbiter.sv
// Per-hart commit-trace FIFOs serialised round-robin onto one co-simulation checker stream.
// Define COSIM_ARB_STATS_EN to build the saturating per-hart drop counters.
module cosim_trace_arbiter #(
    parameter int NHARTS = 2,
    parameter int DEPTH  = 8,
    parameter int REC_W  = 227
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [63:0]               cycle,
    input  logic [NHARTS*2*REC_W-1:0] in_rec,
    cosim_trace_if.master             chk,
    output logic [NHARTS-1:0]         overflow,
    output logic                      all_empty,
    output logic [NHARTS*32-1:0]      drop_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int HID_W = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    // Lane field offsets are anchored at the valid bit; iaddr fills what remains at the top.
    localparam int CAUSE_LSB = 66;
    localparam int EXC_BIT   = 131;

    typedef struct packed {
        logic [REC_W-1:0] rec;
        logic [63:0]      cyc;
    } entry_t;

    entry_t            mem_q    [NHARTS][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NHARTS];
    logic [PTR_W-1:0]  wr_ptr_d [NHARTS];
    logic [PTR_W-1:0]  rd_ptr_q [NHARTS];
    logic [PTR_W-1:0]  rd_ptr_d [NHARTS];
    logic [PTR_W-1:0]  free_s   [NHARTS];
    logic [REC_W-1:0]  lane0    [NHARTS];
    logic [REC_W-1:0]  lane1    [NHARTS];
    logic [1:0]        k        [NHARTS];
    logic [AW-1:0]     idx0     [NHARTS];
    logic [AW-1:0]     idx1     [NHARTS];
    logic [NHARTS-1:0] mean0, mean1, admit, drop, pop, ne_q, ne_d;
    logic [NHARTS-1:0] overflow_q;
    logic [HID_W-1:0]  grant_q, grant_d, rr_q, rr_d;
    logic              handshake, hold;
    entry_t            head;

    function automatic logic [HID_W-1:0] rr_pick(input logic [NHARTS-1:0] req,
                                                 input logic [HID_W-1:0]  start);
        logic [HID_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < NHARTS; i++) begin
            idx = (int'(start) + i) % NHARTS;
            if (!found && req[idx]) begin
                pick  = HID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // NOTE: every element is assigned on every pass, so no latch can be inferred here.
    always_comb begin
        for (int h = 0; h < NHARTS; h++) begin
            lane0[h]    = in_rec[(2*h)*REC_W +: REC_W];
            lane1[h]    = in_rec[(2*h+1)*REC_W +: REC_W];
            mean0[h]    = lane0[h][0] | lane0[h][EXC_BIT] | (|lane0[h][CAUSE_LSB +: 64]);
            mean1[h]    = lane1[h][0] | lane1[h][EXC_BIT] | (|lane1[h][CAUSE_LSB +: 64]);
            k[h]        = {1'b0, mean0[h]} + {1'b0, mean1[h]};
            // Room is judged on start-of-cycle occupancy; a same-cycle pop does not help.
            free_s[h]   = PTR_W'(DEPTH) - (wr_ptr_q[h] - rd_ptr_q[h]);
            admit[h]    = (k[h] != 2'd0) && (free_s[h] >= PTR_W'(k[h]));
            drop[h]     = free_s[h] < PTR_W'(k[h]);
            idx0[h]     = wr_ptr_q[h][AW-1:0];
            idx1[h]     = idx0[h] + AW'(mean0[h]);
            wr_ptr_d[h] = wr_ptr_q[h] + (admit[h] ? PTR_W'(k[h]) : '0);
            ne_q[h]     = wr_ptr_q[h] != rd_ptr_q[h];
        end
    end

    assign handshake = chk.out_valid && chk.out_ready;
    assign hold      = chk.out_valid && !chk.out_ready;

    // The grant is chosen from next-cycle occupancy so a fresh entry shows one cycle later.
    always_comb begin
        for (int h = 0; h < NHARTS; h++) begin
            pop[h]      = handshake && (grant_q == HID_W'(h));
            rd_ptr_d[h] = rd_ptr_q[h] + PTR_W'(pop[h]);
            ne_d[h]     = wr_ptr_d[h] != rd_ptr_d[h];
        end
        rr_d    = handshake ? HID_W'((int'(grant_q) + 1) % NHARTS) : rr_q;
        grant_d = hold ? grant_q : rr_pick(ne_d, rr_d);
    end

    always_comb begin
        head = mem_q[0][rd_ptr_q[0][AW-1:0]];
        for (int h = 1; h < NHARTS; h++) begin
            if (grant_q == HID_W'(h)) head = mem_q[h][rd_ptr_q[h][AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int h = 0; h < NHARTS; h++) begin
                wr_ptr_q[h] <= '0;
                rd_ptr_q[h] <= '0;
            end
            grant_q    <= '0;
            rr_q       <= '0;
            overflow_q <= '0;
        end else begin
            for (int h = 0; h < NHARTS; h++) begin
                wr_ptr_q[h] <= wr_ptr_d[h];
                rd_ptr_q[h] <= rd_ptr_d[h];
            end
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            overflow_q <= overflow_q | drop;
        end
    end

    // NOTE: entry storage is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clock) begin
        for (int h = 0; h < NHARTS; h++) begin
            if (admit[h]) begin
                if (mean0[h]) mem_q[h][idx0[h]] <= {lane0[h], cycle};
                if (mean1[h]) mem_q[h][idx1[h]] <= {lane1[h], cycle};
            end
        end
    end

    assign chk.out_valid  = |ne_q;
    assign chk.out_hartid = grant_q;
    assign chk.out_rec    = head.rec;
    assign chk.out_cycle  = head.cyc;
    assign overflow       = overflow_q;
    assign all_empty      = ~|ne_q;

`ifdef COSIM_ARB_STATS_EN
    logic [31:0] drop_cnt_q [NHARTS];
    logic [32:0] drop_sum   [NHARTS];

    always_comb begin
        for (int h = 0; h < NHARTS; h++) begin
            drop_sum[h] = {1'b0, drop_cnt_q[h]} + 33'(k[h]);
        end
    end

    always_ff @(posedge clock) begin
        for (int h = 0; h < NHARTS; h++) begin
            if (!reset) begin
                drop_cnt_q[h] <= '0;
            end else if (drop[h]) begin
                drop_cnt_q[h] <= drop_sum[h][32] ? 32'hFFFF_FFFF : drop_sum[h][31:0];
            end
        end
    end

    for (genvar g = 0; g < NHARTS; g++) begin : g_drop_cnt
        assign drop_count[g*32 +: 32] = drop_cnt_q[g];
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_cosim_trace_arbiter.sv
// Directed bench for cosim_trace_arbiter: per-hart scoreboard queues filled at drive time,
// drained by a handshake monitor; also checks reset, round-robin order, hold and overflow.
module tb_cosim_trace_arbiter;
    localparam int NH    = 2;
    localparam int DEPTH = 8;
    localparam int RW    = 227;
`ifdef COSIM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [RW-1:0] rec;
        logic [63:0]   cyc;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset;
    logic [63:0]        cyc;
    logic [NH*2*RW-1:0] in_rec;
    logic [NH-1:0]      overflow;
    logic               all_empty;
    logic [NH*32-1:0]   drop_count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q [NH][$];
    int   hid_log [$];

    logic [RW-1:0] r_a, r_b, r_c;

    cosim_trace_if #(.NHARTS(NH), .REC_W(RW)) trace_if ();

    cosim_trace_arbiter #(.NHARTS(NH), .DEPTH(DEPTH), .REC_W(RW)) dut (
        .clock      (clock),
        .reset      (reset),
        .cycle      (cyc),
        .in_rec     (in_rec),
        .chk        (trace_if),
        .overflow   (overflow),
        .all_empty  (all_empty),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_rec(input logic [63:0] iaddr, input logic exc,
                                             input logic [63:0] cause, input logic valid);
        logic [RW-1:0] r;
        r            = '0;
        r[0]         = valid;
        r[64:1]      = iaddr ^ 64'hA5A5_0000_0000_5A5A;
        r[65]        = 1'b1;
        r[129:66]    = cause;
        r[131]       = exc;
        r[163:132]   = iaddr[31:0] ^ 32'h0000_0013;
        r[RW-1:164]  = iaddr[RW-165:0];
        return r;
    endfunction

    task automatic set_lane(input int h, input int l, input logic [RW-1:0] rec);
        in_rec[(2*h+l)*RW +: RW] = rec;
    endtask

    task automatic expect_rec(input int h, input logic [RW-1:0] rec);
        exp_t e;
        e.rec = rec;
        e.cyc = cyc;
        sb_q[h].push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc = cyc + 64'd1;
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        in_rec             = '0;
        trace_if.out_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int h = 0; h < NH; h++) sb_q[h].delete();
        hid_log.delete();
    endtask

    task automatic drain(input string tag);
        int n;
        n                  = 0;
        trace_if.out_ready = 1'b1;
        while (all_empty !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        @(negedge clock);
        check(tag, 256'(all_empty), 256'(1));
        for (int h = 0; h < NH; h++) check({tag, "_sb_left"}, 256'(sb_q[h].size()), 256'(0));
    endtask

    task automatic check_log(input string tag, input int n, input int pattern [8]);
        check({tag, "_len"}, 256'(hid_log.size()), 256'(n));
        for (int i = 0; i < n; i++) begin
            check(tag, 256'((i < hid_log.size()) ? hid_log[i] : 99), 256'(pattern[i]));
        end
    endtask

    // NOTE: outputs are sampled on the falling edge, well away from the edge that moves them.
    always @(negedge clock) begin
        int   h;
        exp_t e;
        if (reset === 1'b1 && trace_if.out_valid === 1'b1 && trace_if.out_ready === 1'b1) begin
            h = int'(trace_if.out_hartid);
            hid_log.push_back(h);
            check("sb_has_entry", 256'(sb_q[h].size() != 0), 256'(1));
            if (sb_q[h].size() != 0) begin
                e = sb_q[h].pop_front();
                check("out_rec", 256'(trace_if.out_rec), 256'(e.rec));
                check("out_cycle", 256'(trace_if.out_cycle), 256'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_pat [8];
        int hold_pat [8];
        reset              = 1'b0;
        cyc                = '0;
        in_rec             = '0;
        trace_if.out_ready = 1'b0;

        // Reset held with every lane valid: nothing may be enqueued.
        for (int l = 0; l < 2*NH; l++) set_lane(l / 2, l % 2, mk_rec(64'h100 + 64'(l), 1'b0, 64'd0, 1'b1));
        repeat (3) begin
            step();
            @(negedge clock);
            check("rst_valid", 256'(trace_if.out_valid), 256'(0));
            check("rst_empty", 256'(all_empty), 256'(1));
            check("rst_ovf", 256'(overflow), 256'(0));
        end
        in_rec = '0;
        reset  = 1'b1;
        step();
        @(negedge clock);
        check("post_rst_empty", 256'(all_empty), 256'(1));
        check("post_rst_valid", 256'(trace_if.out_valid), 256'(0));

        // Single hart, both lanes in one cycle.
        do_reset();
        trace_if.out_ready = 1'b1;
        cyc = 64'd10;
        r_a = mk_rec(64'h8000_0000, 1'b0, 64'd0, 1'b1);
        r_b = mk_rec(64'h8000_0004, 1'b0, 64'd0, 1'b1);
        set_lane(0, 0, r_a);
        set_lane(0, 1, r_b);
        expect_rec(0, r_a);
        expect_rec(0, r_b);
        step();
        in_rec = '0;
        @(negedge clock);
        check("lat1_valid", 256'(trace_if.out_valid), 256'(1));
        check("lat1_rec", 256'(trace_if.out_rec), 256'(r_a));
        check("lat1_hart", 256'(trace_if.out_hartid), 256'(0));
        check("lat1_cycle", 256'(trace_if.out_cycle), 256'(10));
        step();
        @(negedge clock);
        check("second_rec", 256'(trace_if.out_rec), 256'(r_b));
        check("second_cycle", 256'(trace_if.out_cycle), 256'(10));
        drain("single_drain");

        // Round-robin between two busy harts.
        do_reset();
        trace_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r_a = mk_rec(64'h1000 + 64'(4*i), 1'b0, 64'd0, 1'b1);
            r_b = mk_rec(64'h2000 + 64'(4*i), 1'b0, 64'd0, 1'b1);
            set_lane(0, 0, r_a);
            set_lane(1, 0, r_b);
            expect_rec(0, r_a);
            expect_rec(1, r_b);
            step();
        end
        in_rec = '0;
        drain("rr_drain");
        rr_pat = '{0, 1, 0, 1, 0, 1, 0, 1};
        check_log("rr_order", 8, rr_pat);

        // Backpressure: hart1 arrives while hart0 holds the grant and rr_ptr favours hart1.
        do_reset();
        trace_if.out_ready = 1'b1;
        r_a = mk_rec(64'h3000, 1'b0, 64'd0, 1'b1);
        set_lane(0, 0, r_a);
        expect_rec(0, r_a);
        step();
        in_rec = '0;
        step();
        trace_if.out_ready = 1'b0;
        r_b = mk_rec(64'h3004, 1'b0, 64'd0, 1'b1);
        set_lane(0, 0, r_b);
        expect_rec(0, r_b);
        step();
        in_rec = '0;
        r_c = mk_rec(64'h3100, 1'b0, 64'd0, 1'b1);
        set_lane(1, 0, r_c);
        expect_rec(1, r_c);
        step();
        in_rec = '0;
        repeat (5) begin
            @(negedge clock);
            check("hold_valid", 256'(trace_if.out_valid), 256'(1));
            check("hold_hart", 256'(trace_if.out_hartid), 256'(0));
            check("hold_rec", 256'(trace_if.out_rec), 256'(r_b));
            step();
        end
        drain("hold_drain");
        hold_pat = '{0, 0, 1, 0, 0, 0, 0, 0};
        check_log("hold_order", 3, hold_pat);

        // Overflow: five pairs into an 8-deep FIFO with the checker stalled.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            r_a = mk_rec(64'h4000 + 64'(8*i), 1'b0, 64'd0, 1'b1);
            r_b = mk_rec(64'h4004 + 64'(8*i), 1'b0, 64'd0, 1'b1);
            set_lane(0, 0, r_a);
            set_lane(0, 1, r_b);
            if (i < 4) begin
                expect_rec(0, r_a);
                expect_rec(0, r_b);
            end
            step();
            if (i == 3) begin
                @(negedge clock);
                check("ovf_not_yet", 256'(overflow), 256'(0));
            end
        end
        in_rec = '0;
        @(negedge clock);
        check("ovf_set", 256'(overflow), 256'(2'b01));
        check("ovf_cnt0", 256'(drop_count[31:0]), STATS ? 256'(2) : 256'(0));
        check("ovf_cnt1", 256'(drop_count[63:32]), 256'(0));
        check("ovf_not_empty", 256'(all_empty), 256'(0));
        drain("ovf_drain_a");
        check("ovf_sticky", 256'(overflow), 256'(2'b01));

        // Seven singles, then a pair that must drop whole, then a lone lane-1 that fits.
        trace_if.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            r_a = mk_rec(64'h5000 + 64'(4*i), 1'b0, 64'd0, 1'b1);
            set_lane(0, 0, r_a);
            expect_rec(0, r_a);
            step();
        end
        set_lane(0, 0, mk_rec(64'h5100, 1'b0, 64'd0, 1'b1));
        set_lane(0, 1, mk_rec(64'h5104, 1'b0, 64'd0, 1'b1));
        step();
        in_rec = '0;
        r_c = mk_rec(64'h5200, 1'b0, 64'd0, 1'b1);
        set_lane(0, 1, r_c);
        expect_rec(0, r_c);
        step();
        in_rec = '0;
        @(negedge clock);
        check("pair_drop_cnt", 256'(drop_count[31:0]), STATS ? 256'(4) : 256'(0));
        // Full FIFO: a same-cycle pop must not make room for this push.
        trace_if.out_ready = 1'b1;
        set_lane(0, 0, mk_rec(64'h5300, 1'b0, 64'd0, 1'b1));
        step();
        in_rec = '0;
        @(negedge clock);
        check("full_pop_cnt", 256'(drop_count[31:0]), STATS ? 256'(5) : 256'(0));
        drain("ovf_drain_b");

        // Cause-only and exception-only lanes are meaningful; an all-quiet lane is not.
        do_reset();
        trace_if.out_ready = 1'b1;
        r_a = mk_rec(64'h6000, 1'b0, 64'h8000_0000_0000_0007, 1'b0);
        set_lane(1, 0, r_a);
        expect_rec(1, r_a);
        step();
        in_rec = '0;
        @(negedge clock);
        check("cause_valid", 256'(trace_if.out_valid), 256'(1));
        check("cause_hart", 256'(trace_if.out_hartid), 256'(1));
        drain("cause_drain");
        set_lane(0, 1, mk_rec(64'h6100, 1'b0, 64'd0, 1'b0));
        step();
        in_rec = '0;
        @(negedge clock);
        check("quiet_empty", 256'(all_empty), 256'(1));
        check("quiet_valid", 256'(trace_if.out_valid), 256'(0));
        r_b = mk_rec(64'h6200, 1'b1, 64'd0, 1'b0);
        set_lane(0, 0, r_b);
        expect_rec(0, r_b);
        step();
        in_rec = '0;
        drain("exc_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
